// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life run/step/clear sequencer.
package gol_pkg;

   localparam int unsigned TICK_BASE_DEFAULT = 250000;
   localparam int          GEN_W             = 16;
   localparam int          TICK_W            = 32;
   localparam int          STATE_W           = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_SETUP = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_STEP  = 3'd3,
      ST_CLEAR = 3'd4
   } state_e;

   // Tick period for a given base and speed select.
   function automatic logic [TICK_W-1:0] tick_period(input logic [TICK_W-1:0] base,
                                                     input logic [1:0]        spd);
      return base << spd;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: pulses while the input is high and was low on the previous cycle.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_d;
      end
   end

   assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/gol_sequencer.sv
// Run/pause/step/clear controller for the Game-of-Life grid: generation ticks,
// clear pulses, user edit grants and a saturating generation counter.
module gol_sequencer
   import gol_pkg::*;
#(
   parameter int unsigned TICK_BASE = TICK_BASE_DEFAULT
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               run_sw,
   input  logic               step_key,
   input  logic               clear_key,
   input  logic               set_initial,
   input  logic               board_empty,
   input  logic [1:0]         speed,
   output logic               start_game,
   output logic               edit_en,
   output logic               gen_tick,
   output logic               clear_grid,
   output logic [GEN_W-1:0]   gen_count,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [STATE_W-1:0] S_SETUP = STATE_W'(ST_SETUP);
   localparam logic [STATE_W-1:0] S_RUN   = STATE_W'(ST_RUN);
   localparam logic [STATE_W-1:0] S_PAUSE = STATE_W'(ST_PAUSE);
   localparam logic [STATE_W-1:0] S_STEP  = STATE_W'(ST_STEP);
   localparam logic [STATE_W-1:0] S_CLEAR = STATE_W'(ST_CLEAR);

   logic [1:0]         w_keys;
   logic [1:0]         w_rise;
   logic               w_step_edge;
   logic               w_clear_edge;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_next;

   logic [TICK_W-1:0]  r_tick_cnt;
   logic [TICK_W-1:0]  w_tick_cnt_next;
   logic [TICK_W-1:0]  w_period_last;
   logic               r_run_d;
   logic               w_run_counting;
   logic               w_tick_fire;
   logic               w_tick_next;

   logic               r_gen_tick;
   logic               r_clear_grid;
   logic [GEN_W-1:0]   r_gen_count;

   assign w_keys = {clear_key, step_key};

   for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      rise_detect u_rise (
         .clk    (clk),
         .reset  (reset),
         .i_d    (w_keys[gi]),
         .o_rise (w_rise[gi])
      );
   end

   assign w_step_edge  = w_rise[0];
   assign w_clear_edge = w_rise[1];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_SETUP: begin
            if (w_clear_edge)     w_state_next = S_CLEAR;
            else if (run_sw)      w_state_next = S_RUN;
            else if (w_step_edge) w_state_next = S_STEP;
         end
         S_RUN: begin
            if (w_clear_edge)     w_state_next = S_CLEAR;
            else if (!run_sw)     w_state_next = S_PAUSE;
            else if (board_empty) w_state_next = S_SETUP;
         end
         S_PAUSE: begin
            if (w_clear_edge)     w_state_next = S_CLEAR;
            else if (run_sw)      w_state_next = S_RUN;
            else if (w_step_edge) w_state_next = S_STEP;
         end
         S_STEP:  w_state_next = S_PAUSE;
         S_CLEAR: w_state_next = S_SETUP;
         default: w_state_next = S_SETUP;
      endcase
   end

   // The first RUN cycle (r_run_d still low) holds the counter at zero, which
   // puts the first tick P+1 cycles after entry while keeping a period of P.
   assign w_period_last  = tick_period(TICK_W'(TICK_BASE), speed) - TICK_W'(1);
   assign w_run_counting = (r_state == S_RUN) && r_run_d;
   assign w_tick_fire    = w_run_counting && (r_tick_cnt == w_period_last);

   always_comb begin
      w_tick_cnt_next = '0;
      if (w_run_counting && !w_tick_fire) begin
         w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
      end
   end

   // A RUN tick only counts if the FSM stays in RUN across the firing edge.
   assign w_tick_next = (w_tick_fire && (w_state_next == S_RUN)) ||
                        (w_state_next == S_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_SETUP;
         r_tick_cnt   <= '0;
         r_run_d      <= 1'b0;
         r_gen_tick   <= 1'b0;
         r_clear_grid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_tick_cnt   <= w_tick_cnt_next;
         r_run_d      <= (r_state == S_RUN);
         r_gen_tick   <= w_tick_next;
         r_clear_grid <= (w_state_next == S_CLEAR);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gen_count <= '0;
      end else if (w_state_next == S_CLEAR) begin
         r_gen_count <= '0;
      end else if (w_tick_next && (r_gen_count != {GEN_W{1'b1}})) begin
         r_gen_count <= r_gen_count + GEN_W'(1);
      end
   end

   assign start_game = (r_state != S_SETUP) && (r_state != S_CLEAR);
   assign edit_en    = set_initial && (r_state == S_SETUP);
   assign gen_tick   = r_gen_tick;
   assign clear_grid = r_clear_grid;
   assign gen_count  = r_gen_count;
   assign state_o    = r_state;

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed bench for gol_sequencer with TICK_BASE = 4: a cycle-by-cycle vector
// table plus short sequences for saturation, reset, drop and speed-change cases.
module tb_gol_sequencer;

   logic        clk;
   logic        reset;
   logic        run_sw;
   logic        step_key;
   logic        clear_key;
   logic        set_initial;
   logic        board_empty;
   logic [1:0]  speed;
   logic        start_game;
   logic        edit_en;
   logic        gen_tick;
   logic        clear_grid;
   logic [15:0] gen_count;
   logic [2:0]  state_o;

   int checks = 0;
   int errors = 0;

   gol_sequencer #(.TICK_BASE(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .run_sw      (run_sw),
      .step_key    (step_key),
      .clear_key   (clear_key),
      .set_initial (set_initial),
      .board_empty (board_empty),
      .speed       (speed),
      .start_game  (start_game),
      .edit_en     (edit_en),
      .gen_tick    (gen_tick),
      .clear_grid  (clear_grid),
      .gen_count   (gen_count),
      .state_o     (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        run;
      logic        step;
      logic        clr;
      logic        set;
      logic        empty;
      logic [1:0]  spd;
      logic [2:0]  e_state;
      logic        e_sg;
      logic        e_edit;
      logic        e_tick;
      logic        e_clrg;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic run, input logic step, input logic clr, input logic set,
                      input logic [2:0] st, input logic sg, input logic ed, input logic tk,
                      input logic cg, input logic [15:0] cnt);
      vec_t v;
      v.run = run; v.step = step; v.clr = clr; v.set = set; v.empty = 1'b0; v.spd = 2'd0;
      v.e_state = st; v.e_sg = sg; v.e_edit = ed; v.e_tick = tk; v.e_clrg = cg; v.e_cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; run_sw = 1'b0; step_key = 1'b0; clear_key = 1'b0;
      set_initial = 1'b0; board_empty = 1'b0; speed = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int first;
      int nticks;

      reset = 1'b1; run_sw = 1'b0; step_key = 1'b0; clear_key = 1'b0;
      set_initial = 1'b1; board_empty = 1'b0; speed = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", 32'(state_o), 32'd0);
      check("reset start_game", 32'(start_game), 32'd0);
      check("reset edit_en", 32'(edit_en), 32'd1);
      check("reset gen_tick", 32'(gen_tick), 32'd0);
      check("reset clear_grid", 32'(clear_grid), 32'd0);
      check("reset gen_count", 32'(gen_count), 32'd0);
      $display("reset: state=%0d gen_count=%0d edit_en=%0b", state_o, gen_count, edit_en);
      do_reset();

      // run  step clr  set   state sg ed tk cg cnt
      add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1,   1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0,   1, 1, 0, 1, 0, 1);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 1);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 1);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 1);
      add(1, 0, 0, 0,   1, 1, 0, 1, 0, 2);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 2);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 2);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 2);
      add(1, 0, 0, 0,   1, 1, 0, 1, 0, 3);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 3);
      add(0, 0, 0, 0,   2, 1, 0, 0, 0, 3);
      add(0, 1, 0, 0,   3, 1, 0, 1, 0, 4);
      add(0, 1, 0, 0,   2, 1, 0, 0, 0, 4);
      add(0, 0, 0, 0,   2, 1, 0, 0, 0, 4);
      add(0, 1, 0, 0,   3, 1, 0, 1, 0, 5);
      add(0, 0, 0, 0,   2, 1, 0, 0, 0, 5);
      add(0, 1, 0, 0,   3, 1, 0, 1, 0, 6);
      add(0, 0, 0, 0,   2, 1, 0, 0, 0, 6);
      add(0, 0, 0, 1,   2, 1, 0, 0, 0, 6);
      add(1, 0, 0, 0,   1, 1, 0, 0, 0, 6);
      add(0, 0, 1, 0,   4, 0, 0, 0, 1, 0);
      add(0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0,   4, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0,   3, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0,   2, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0,   4, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         run_sw = tbl[i].run; step_key = tbl[i].step; clear_key = tbl[i].clr;
         set_initial = tbl[i].set; board_empty = tbl[i].empty; speed = tbl[i].spd;
         @(posedge clk);
         #1;
         check($sformatf("v%0d state", i), 32'(state_o), 32'(tbl[i].e_state));
         check($sformatf("v%0d start_game", i), 32'(start_game), 32'(tbl[i].e_sg));
         check($sformatf("v%0d edit_en", i), 32'(edit_en), 32'(tbl[i].e_edit));
         check($sformatf("v%0d gen_tick", i), 32'(gen_tick), 32'(tbl[i].e_tick));
         check($sformatf("v%0d clear_grid", i), 32'(clear_grid), 32'(tbl[i].e_clrg));
         check($sformatf("v%0d gen_count", i), 32'(gen_count), 32'(tbl[i].e_cnt));
         $display("vec %0d: state=%0d sg=%0b edit=%0b tick=%0b clr=%0b cnt=%0d",
                  i, state_o, start_game, edit_en, gen_tick, clear_grid, gen_count);
      end

      // board_empty in RUN returns to SETUP and stops ticking
      do_reset();
      @(negedge clk); run_sw = 1'b1;
      first = -1;
      for (int k = 0; k < 20 && first < 0; k++) begin
         @(posedge clk); #1;
         if (gen_tick) first = k;
      end
      check("empty first tick", 32'(first), 32'd5);
      @(negedge clk); board_empty = 1'b1;
      @(posedge clk); #1;
      check("empty state", 32'(state_o), 32'd0);
      nticks = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (gen_tick) nticks++;
      end
      check("empty no ticks", 32'(nticks), 32'd0);
      check("empty count kept", 32'(gen_count), 32'd1);
      $display("board_empty: first=%0d ticks_after=%0d cnt=%0d", first, nticks, gen_count);

      // saturation at 16'hFFFF
      do_reset();
      @(negedge clk); step_key = 1'b1;
      @(negedge clk); step_key = 1'b0;
      @(negedge clk);
      force dut.r_gen_count = 16'hFFFE;
      @(posedge clk); #1;
      release dut.r_gen_count;
      @(posedge clk); #1;
      check("preload", 32'(gen_count), 32'hFFFE);
      check("preload state", 32'(state_o), 32'd2);
      @(negedge clk); run_sw = 1'b1;
      nticks = 0;
      for (int k = 0; k < 40 && nticks < 3; k++) begin
         @(posedge clk); #1;
         if (gen_tick) begin
            nticks++;
            check($sformatf("sat tick%0d", nticks), 32'(gen_count), 32'hFFFF);
         end
      end
      check("sat tick count", 32'(nticks), 32'd3);
      $display("saturate: ticks=%0d cnt=%0h", nticks, gen_count);

      // reset one cycle before a tick suppresses it
      do_reset();
      @(negedge clk); run_sw = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b1; run_sw = 1'b0;
      @(posedge clk); #1;
      check("rst tick", 32'(gen_tick), 32'd0);
      check("rst state", 32'(state_o), 32'd0);
      @(negedge clk); reset = 1'b0;
      nticks = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (gen_tick) nticks++;
      end
      check("rst no ticks", 32'(nticks), 32'd0);
      $display("reset-before-tick: tick=%0b ticks_after=%0d", gen_tick, nticks);

      // leaving RUN on the firing edge drops the tick
      do_reset();
      @(negedge clk); run_sw = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); run_sw = 1'b0;
      @(posedge clk); #1;
      check("drop tick", 32'(gen_tick), 32'd0);
      check("drop state", 32'(state_o), 32'd2);
      check("drop count", 32'(gen_count), 32'd0);
      $display("drop: tick=%0b state=%0d cnt=%0d", gen_tick, state_o, gen_count);

      // speed=1 gives P=8; lowering speed once the counter is past 3 must not fire
      do_reset();
      @(negedge clk); run_sw = 1'b1; speed = 2'd1;
      first = -1;
      for (int k = 0; k < 20 && first < 0; k++) begin
         @(posedge clk); #1;
         if (gen_tick) first = k;
      end
      check("speed1 first tick", 32'(first), 32'd9);
      repeat (5) @(posedge clk);
      @(negedge clk); speed = 2'd0;
      nticks = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (gen_tick) nticks++;
      end
      check("speed drop no early tick", 32'(nticks), 32'd0);
      check("speed state", 32'(state_o), 32'd1);
      $display("speed: first=%0d ticks_after_change=%0d", first, nticks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
